// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder for the memory-stage data port. Each access accepted from the
// memory stage is latched and issued as one single-beat transaction on a
// valid/ready data bus. The pipeline is stalled until that transaction
// completes.
//
// Optional feature macro: DMEM_WRITE_POST_EN (posted writes).
//   When defined, a write leaves REQ straight for DONE on the handshake.
//   A 1-bit outstanding flag then blocks new accesses until the write's
//   response arrives.
//
// Ports
//   clk, rst        clock and reset (reset is asynchronous, active-high)
//   mem_en          access request from the memory stage, held while stalled
//   mem_wen[3:0]    byte write strobes; 0 means read
//   mem_addr[31:0]  byte address
//   mem_wdata[31:0] write data, already lane-replicated
//   mem_rdata[31:0] registered read data, held until the next read capture
//   mem_stall       combinational pipeline stall
//   bus_error       one-cycle pulse for an error response
//   bus_req_*       request channel: valid/ready, write, addr, wstrb, wdata
//   bus_resp_*      response channel: valid, data, err (always accepted)
//   dbg_state[1:0]  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Handshake: a request transfers on a rising edge where bus_req_valid and
// bus_req_ready are both high. Once valid rises, the request fields stay
// stable and valid stays high until that transfer. Ready may depend on valid.
// A response transfers on any edge where bus_resp_valid is high, because it
// is always accepted. A response is used only while one is expected and is
// dropped otherwise.
// -----------------------------------------------------------------------------
module dmem_responder (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic [3:0]  mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_stall,
   output logic        bus_error,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_req_write,
   output logic [31:0] bus_req_addr,
   output logic [3:0]  bus_req_wstrb,
   output logic [31:0] bus_req_wdata,
   input  logic        bus_resp_valid,
   input  logic [31:0] bus_resp_data,
   input  logic        bus_resp_err,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       wr_pending;
   logic       accept;
   logic       req_fire;
   logic       resp_in_wait;
   logic       err_nxt;
   logic       skip_wait;

   assign accept       = (state == ST_IDLE) & mem_en & ~wr_pending;
   assign req_fire     = (state == ST_REQ) & bus_req_ready;
   assign resp_in_wait = (state == ST_WAIT) & bus_resp_valid;

`ifdef DMEM_WRITE_POST_EN
   logic post_resp;

   // Any response seen while the flag is set belongs to the posted write.
   assign post_resp = wr_pending & bus_resp_valid;
   assign skip_wait = bus_req_write;
   assign err_nxt   = (resp_in_wait | post_resp) & bus_resp_err;

   // When a clear and a set happen together, the set wins. This gives the
   // behaviour of clearing first and then setting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wr_pending <= 1'b0;
      else if (req_fire & bus_req_write)
         wr_pending <= 1'b1;
      else if (post_resp)
         wr_pending <= 1'b0;
   end
`else
   assign wr_pending = 1'b0;
   assign skip_wait  = 1'b0;
   assign err_nxt    = resp_in_wait & bus_resp_err;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept)         state_nxt = ST_REQ;
         ST_REQ:  if (bus_req_ready)  state_nxt = skip_wait ? ST_DONE : ST_WAIT;
         ST_WAIT: if (bus_resp_valid) state_nxt = ST_DONE;
         default:                     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         mem_rdata     <= 32'd0;
         bus_error     <= 1'b0;
         bus_req_write <= 1'b0;
         bus_req_addr  <= 32'd0;
         bus_req_wstrb <= 4'd0;
         bus_req_wdata <= 32'd0;
      end else begin
         state     <= state_nxt;
         bus_error <= err_nxt;
         if (accept) begin
            bus_req_write <= |mem_wen;
            bus_req_addr  <= mem_addr;
            bus_req_wstrb <= mem_wen;
            bus_req_wdata <= mem_wdata;
         end
         // Reads capture even after a flush. An error response reads as 0.
         if (resp_in_wait & ~bus_req_write)
            mem_rdata <= bus_resp_err ? 32'd0 : bus_resp_data;
      end
   end

   // Valid comes straight from state, so an asynchronous reset drops it at once.
   assign bus_req_valid = (state == ST_REQ);
   // The pipeline advances at the end of DONE.
   assign mem_stall     = mem_en & (state != ST_DONE);
   assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. It uses:
//   - a cycle table of directed sequences,
//   - hand-written reset and posted-write sequences,
//   - randomized transactions checked against a transaction-level model:
//       stall length = 3 + ready delay + response delay,
//       mem_rdata follows the last completed read.
// Inputs change and outputs are sampled on the falling edge (+1ns).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

   localparam logic [1:0] S_I = 2'd0;
   localparam logic [1:0] S_R = 2'd1;
   localparam logic [1:0] S_W = 2'd2;
   localparam logic [1:0] S_D = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_stall;
   logic        bus_error;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_write;
   logic [31:0] bus_req_addr;
   logic [3:0]  bus_req_wstrb;
   logic [31:0] bus_req_wdata;
   logic        bus_resp_valid;
   logic [31:0] bus_resp_data;
   logic        bus_resp_err;
   logic [1:0]  dbg_state;

   dmem_responder dut (
      .clk(clk), .rst(rst),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_stall(mem_stall), .bus_error(bus_error),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr),
      .bus_req_wstrb(bus_req_wstrb), .bus_req_wdata(bus_req_wdata),
      .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
      .bus_resp_err(bus_resp_err), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // ---------------- cycle table ----------------
   typedef struct {
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        rerr;
      logic        e_stall;
      logic        e_valid;
      logic [1:0]  e_state;
      logic [31:0] e_rdata;
      logic        e_err;
      logic        chk;
      logic        e_write;
      logic [31:0] e_addr;
      logic [3:0]  e_wstrb;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic void row(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic rdy, input logic rv,
                               input logic [31:0] rd, input logic rerr, input logic e_stall,
                               input logic e_valid, input logic [1:0] e_state,
                               input logic [31:0] e_rdata, input logic e_err);
      vec_t v;
      v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
      v.rdy = rdy; v.rv = rv; v.rd = rd; v.rerr = rerr;
      v.e_stall = e_stall; v.e_valid = e_valid; v.e_state = e_state;
      v.e_rdata = e_rdata; v.e_err = e_err;
      v.chk = 1'b0; v.e_write = 1'b0; v.e_addr = 32'd0; v.e_wstrb = 4'd0; v.e_wdata = 32'd0;
      vecs.push_back(v);
   endfunction

   function automatic void fields(input logic w, input logic [31:0] a, input logic [3:0] s,
                                  input logic [31:0] d);
      int k = vecs.size() - 1;
      vecs[k].chk = 1'b1; vecs[k].e_write = w; vecs[k].e_addr = a;
      vecs[k].e_wstrb = s; vecs[k].e_wdata = d;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      mem_en = 1'b0; mem_wen = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = 32'd0; bus_resp_err = 1'b0;
   endtask

   // One randomized access. The bus agent raises ready after d1 REQ cycles.
   // It responds d2 cycles after the handshake. Before the handshake it may
   // drive spurious error responses, which must be ignored.
   task automatic run_txn(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                          input int d1, input int d2, input logic [31:0] rd, input logic err,
                          input logic spur);
      int   stall_cnt = 0;
      int   vcnt = 0;
      int   wcnt = 0;
      int   cyc = 0;
      int   phase = 0;
      bit   done = 0;
      if (wen == 4'd0) last_rd = err ? 32'd0 : rd;
      exp_q.push_back(last_rd);
      @(negedge clk);
      mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata;
      while (!done && cyc < 100) begin
         #1;
         if (mem_stall) stall_cnt++;
         else done = 1;
         if (!done) begin
            bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
            if (phase == 0) begin
               bus_resp_valid = spur; bus_resp_err = spur; bus_resp_data = ~addr;
               if (bus_req_valid) begin
                  if (vcnt == d1) begin
                     bus_req_ready = 1'b1;
                     phase = 1;
                     check("rnd req_addr", bus_req_addr, addr);
                     check("rnd req_wstrb", {28'd0, bus_req_wstrb}, {28'd0, wen});
                     check("rnd req_wdata", bus_req_wdata, wdata);
                     check("rnd req_write", {31'd0, bus_req_write}, {31'd0, |wen});
                  end
                  vcnt++;
               end
            end else if (phase == 1) begin
               if (wcnt == d2) begin
                  bus_resp_valid = 1'b1; bus_resp_data = rd; bus_resp_err = err;
                  phase = 2;
               end
               wcnt++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      if (!done) check("rnd timeout", 32'd1, 32'd0);
      check("rnd stall_cycles", stall_cnt, d1 + d2 + 3);
      check("rnd rdata", mem_rdata, exp_q.pop_front());
      check("rnd bus_error", {31'd0, bus_error}, {31'd0, err});
      idle_inputs();
      @(negedge clk);
      #1;
      check("rnd error_cleared", {31'd0, bus_error}, 32'd0);
      check("rnd back_idle", {30'd0, dbg_state}, {30'd0, S_I});
   endtask

   // ---------------- test ----------------
   initial begin
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst state", {30'd0, dbg_state}, {30'd0, S_I});
      check("rst rdata", mem_rdata, 32'd0);
      check("rst error", {31'd0, bus_error}, 32'd0);
      check("rst valid", {31'd0, bus_req_valid}, 32'd0);
      check("rst write", {31'd0, bus_req_write}, 32'd0);
      check("rst addr", bus_req_addr, 32'd0);
      check("rst wstrb", {28'd0, bus_req_wstrb}, 32'd0);
      check("rst wdata", bus_req_wdata, 32'd0);
      check("rst stall", {31'd0, mem_stall}, 32'd0);

      // Zero-wait read
      row(1, 4'h0, 32'h1000, 0, 0, 0, 0, 0,            1, 0, S_I, 32'h0, 0);
      row(1, 4'h0, 32'h1000, 0, 1, 0, 0, 0,            1, 1, S_R, 32'h0, 0);
      fields(0, 32'h1000, 4'h0, 32'h0);
      row(1, 4'h0, 32'h1000, 0, 0, 1, 32'hDEADBEEF, 0, 1, 0, S_W, 32'h0, 0);
      row(1, 4'h0, 32'h1000, 0, 0, 0, 0, 0,            0, 0, S_D, 32'hDEADBEEF, 0);
      row(0, 4'h0, 32'h0,    0, 0, 0, 0, 0,            0, 0, S_I, 32'hDEADBEEF, 0);
`ifndef DMEM_WRITE_POST_EN
      // Write, ready held low for three REQ cycles
      row(1, 4'h3, 32'h2000, 32'h12341234, 0, 0, 0, 0, 1, 0, S_I, 32'hDEADBEEF, 0);
      for (int k = 0; k < 4; k++) begin
         row(1, 4'h3, 32'h2000, 32'h12341234, (k == 3), 0, 0, 0, 1, 1, S_R, 32'hDEADBEEF, 0);
         fields(1, 32'h2000, 4'h3, 32'h12341234);
      end
      row(1, 4'h3, 32'h2000, 32'h12341234, 0, 1, 32'hAAAAAAAA, 0, 1, 0, S_W, 32'hDEADBEEF, 0);
      row(1, 4'h3, 32'h2000, 32'h12341234, 0, 0, 0, 0, 0, 0, S_D, 32'hDEADBEEF, 0);
      row(0, 4'h0, 32'h0, 0, 0, 0, 0, 0,                0, 0, S_I, 32'hDEADBEEF, 0);
`endif
      // Error read
      row(1, 4'h0, 32'h3000, 0, 0, 0, 0, 0,            1, 0, S_I, 32'hDEADBEEF, 0);
      row(1, 4'h0, 32'h3000, 0, 1, 0, 0, 0,            1, 1, S_R, 32'hDEADBEEF, 0);
      row(1, 4'h0, 32'h3000, 0, 0, 1, 32'h55555555, 1, 1, 0, S_W, 32'hDEADBEEF, 0);
      row(1, 4'h0, 32'h3000, 0, 0, 0, 0, 0,            0, 0, S_D, 32'h0, 1);
      row(0, 4'h0, 32'h0,    0, 0, 0, 0, 0,            0, 0, S_I, 32'h0, 0);
      // Flush in WAIT, then a fresh access right after DONE
      row(1, 4'h0, 32'h4000, 0, 0, 0, 0, 0,            1, 0, S_I, 32'h0, 0);
      row(1, 4'h0, 32'h4000, 0, 1, 0, 0, 0,            1, 1, S_R, 32'h0, 0);
      row(0, 4'h0, 32'h4000, 0, 0, 0, 0, 0,            0, 0, S_W, 32'h0, 0);
      row(0, 4'h0, 32'h4000, 0, 0, 1, 32'h0BADF00D, 0, 0, 0, S_W, 32'h0, 0);
      row(0, 4'h0, 32'h0,    0, 0, 0, 0, 0,            0, 0, S_D, 32'h0BADF00D, 0);
      row(1, 4'h0, 32'h5000, 0, 0, 0, 0, 0,            1, 0, S_I, 32'h0BADF00D, 0);
      row(1, 4'h0, 32'h5000, 0, 1, 0, 0, 0,            1, 1, S_R, 32'h0BADF00D, 0);
      fields(0, 32'h5000, 4'h0, 32'h0);
      row(1, 4'h0, 32'h5000, 0, 0, 1, 32'h11112222, 0, 1, 0, S_W, 32'h0BADF00D, 0);
      row(1, 4'h0, 32'h5000, 0, 0, 0, 0, 0,            0, 0, S_D, 32'h11112222, 0);
      row(0, 4'h0, 32'h0,    0, 0, 0, 0, 0,            0, 0, S_I, 32'h11112222, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         mem_en = vecs[i].en; mem_wen = vecs[i].wen; mem_addr = vecs[i].addr;
         mem_wdata = vecs[i].wdata; bus_req_ready = vecs[i].rdy; bus_resp_valid = vecs[i].rv;
         bus_resp_data = vecs[i].rd; bus_resp_err = vecs[i].rerr;
         #1;
         check($sformatf("vec%0d stall", i), {31'd0, mem_stall}, {31'd0, vecs[i].e_stall});
         check($sformatf("vec%0d valid", i), {31'd0, bus_req_valid}, {31'd0, vecs[i].e_valid});
         check($sformatf("vec%0d state", i), {30'd0, dbg_state}, {30'd0, vecs[i].e_state});
         check($sformatf("vec%0d rdata", i), mem_rdata, vecs[i].e_rdata);
         check($sformatf("vec%0d error", i), {31'd0, bus_error}, {31'd0, vecs[i].e_err});
         if (vecs[i].chk) begin
            check($sformatf("vec%0d write", i), {31'd0, bus_req_write}, {31'd0, vecs[i].e_write});
            check($sformatf("vec%0d addr", i), bus_req_addr, vecs[i].e_addr);
            check($sformatf("vec%0d wstrb", i), {28'd0, bus_req_wstrb}, {28'd0, vecs[i].e_wstrb});
            check($sformatf("vec%0d wdata", i), bus_req_wdata, vecs[i].e_wdata);
         end
      end

      // Reset asserted mid-REQ; a stale response afterwards is ignored
      @(negedge clk);
      idle_inputs();
      mem_en = 1'b1; mem_addr = 32'h6000;
      @(negedge clk);
      #1;
      check("rstreq valid_before", {31'd0, bus_req_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rstreq valid_async", {31'd0, bus_req_valid}, 32'd0);
      check("rstreq state", {30'd0, dbg_state}, {30'd0, S_I});
      check("rstreq rdata", mem_rdata, 32'd0);
      check("rstreq addr", bus_req_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_en = 1'b0;
      bus_resp_valid = 1'b1; bus_resp_data = 32'h77777777; bus_resp_err = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      check("stale state", {30'd0, dbg_state}, {30'd0, S_I});
      check("stale rdata", mem_rdata, 32'd0);
      check("stale error", {31'd0, bus_error}, 32'd0);

      // Randomized transactions
      last_rd = 32'd0;
      for (int t = 0; t < 40; t++) begin
         logic [3:0] wen;
`ifdef DMEM_WRITE_POST_EN
         wen = 4'd0;
`else
         wen = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
`endif
         run_txn($urandom, wen, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                 $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
      end

`ifdef DMEM_WRITE_POST_EN
      // Posted write, then a read; the write response arrives 5 cycles after acceptance
      @(negedge clk);
      mem_en = 1'b1; mem_wen = 4'hF; mem_addr = 32'h7000; mem_wdata = 32'hCAFEF00D;
      #1;
      check("post c0 stall", {31'd0, mem_stall}, 32'd1);
      @(negedge clk);
      bus_req_ready = 1'b1;
      #1;
      check("post c1 valid", {31'd0, bus_req_valid}, 32'd1);
      @(negedge clk);
      bus_req_ready = 1'b0;
      #1;
      check("post c2 state", {30'd0, dbg_state}, {30'd0, S_D});
      check("post c2 stall", {31'd0, mem_stall}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         mem_wen = 4'h0; mem_addr = 32'h7004; mem_wdata = 32'h0;
         bus_resp_valid = (k == 3); bus_resp_data = 32'h0; bus_resp_err = 1'b0;
         #1;
         check($sformatf("post blocked%0d valid", k), {31'd0, bus_req_valid}, 32'd0);
         check($sformatf("post blocked%0d stall", k), {31'd0, mem_stall}, 32'd1);
      end
      @(negedge clk);
      bus_resp_valid = 1'b0;
      #1;
      check("post c7 valid", {31'd0, bus_req_valid}, 32'd0);
      @(negedge clk);
      bus_req_ready = 1'b1;
      #1;
      check("post c8 valid", {31'd0, bus_req_valid}, 32'd1);
      check("post c8 addr", bus_req_addr, 32'h7004);
      @(negedge clk);
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'h12121212;
      @(negedge clk);
      bus_resp_valid = 1'b0;
      #1;
      check("post read rdata", mem_rdata, 32'h12121212);
      check("post read stall", {31'd0, mem_stall}, 32'd0);
      idle_inputs();
      @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the data-side SRAM-style port driven by the memory stage (`mem_en`, `mem_wen`, `mem_addr`, `mem_wdata`, `mem_rdata`). Each accepted access is latched and converted into one single-beat transaction on a valid/ready data bus, while the pipeline is stalled until the transaction completes. The block sits between the memory stage and the data cache/bus arbiter.

## Interface
- No parameters; data and address widths are fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high. One clock; reset is asynchronous and active-high.
- mem_en  in  1  access request from the memory stage. It is combinational and is held while stalled.
- mem_wen  in  4  byte write strobes. 0 means read; non-zero means write.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data, already lane-replicated.
- mem_rdata  out  32  read data; registered.
- mem_stall  out  1  pipeline stall; combinational.
- bus_error  out  1  one-cycle pulse when an error response arrives.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted by the bus.
- bus_req_write  out  1  1 = write.
- bus_req_addr  out  32  latched address, passed through unmodified.
- bus_req_wstrb  out  4  latched strobes.
- bus_req_wdata  out  32  latched write data.
- bus_resp_valid  in  1  response valid. Responses are always accepted; there is no ready signal.
- bus_resp_data  in  32  read data.
- bus_resp_err  in  1  error flag, qualified by bus_resp_valid.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `mem_en`=1 (and the posted-write condition in Configuration is clear), latch addr, wen, wdata and write = |wen, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `bus_req_valid`=1 with the latched fields.
  - On `bus_req_ready`=1, go to WAIT. REQ persists while ready is 0.
- WAIT:
  - On `bus_resp_valid`, go to DONE.
  - For a read, capture `mem_rdata` ← `bus_resp_data`, or ← 0 if `bus_resp_err`.
  - If `bus_resp_err`, pulse `bus_error` in the DONE cycle.
- DONE: unconditionally return to IDLE on the next edge.
- mem_stall = mem_en & (state != DONE).
  - The pipeline advances at the end of the DONE cycle.
  - With `mem_en`=0, stall is 0 in every state.
- Upstream inputs are ignored after latching.
  - If `mem_en` drops mid-transaction (flush), the transaction still completes on the bus and its result is discarded.
  - mem_rdata is still updated for a read.
- `mem_rdata` holds its value until the next read capture. Writes never change it.
- A `bus_resp_valid` outside WAIT (or outside the posted-write window) is ignored.
- Reset values:
  - state IDLE; mem_rdata 0; bus_error 0.
  - bus_req_valid 0; bus_req_write 0; bus_req_addr, bus_req_wstrb, bus_req_wdata all 0.
  - Outstanding-write counter 0.
  - Reset mid-transaction abandons it immediately; `bus_req_valid` drops asynchronously.

## Timing
- Minimum access, cycle-by-cycle:
  - c0: mem_en seen in IDLE.
  - c1: REQ with ready=1.
  - c2: WAIT with resp_valid=1.
  - c3: DONE, stall=0.
- Minimum latency is 4 cycles from mem_en to the stall release. Back-to-back accesses issue at best every 4 cycles.
- `bus_req_*` is stable from REQ entry until the handshake cycle.
- `mem_rdata` is valid from the DONE cycle onward.
- `bus_error` is high exactly in the DONE cycle.

## Configuration
- Macro: `DMEM_WRITE_POST_EN`.
- Defined (posted writes):
  - A write leaves REQ directly to DONE on the handshake. The stall releases one cycle after acceptance.
  - A 1-bit outstanding flag is set at the write handshake and cleared by the next `bus_resp_valid`.
  - IDLE does not accept a new access while the flag is set; the stall is held.
  - A write error pulses `bus_error` in the cycle after its response.
  - A response and a new handshake in the same cycle is legal: clear then set.
- Undefined:
  - Writes follow REQ→WAIT→DONE like reads.
  - No outstanding flag exists.

## Test plan
- Read, zero-wait bus: addr 0x1000, wen 0, resp_data 0xDEADBEEF at c2.
  - stall=1 c0–c2, 0 at c3.
  - mem_rdata = 0xDEADBEEF from c3.
- Write with ready held 0 for 3 cycles: wen 4'b0011, wdata 0x12341234.
  - bus_req_* are stable through all REQ cycles and wstrb=4'b0011.
  - mem_rdata is unchanged.
- Error read: resp_err=1 with data 0x55555555.
  - mem_rdata=0, and bus_error=1 for exactly one cycle (DONE).
- Flush: mem_en drops in WAIT.
  - stall=0 immediately, and the transaction still completes.
  - A new mem_en in the cycle after DONE starts a fresh REQ.
- Reset asserted in REQ.
  - bus_req_valid=0 asynchronously, state IDLE, mem_rdata=0.
  - A stale resp_valid after reset is ignored.
- `DMEM_WRITE_POST_EN`: a write followed by a read, with the write response delayed 5 cycles.
  - Write stall releases 1 cycle after handshake.
  - The read's bus_req_valid does not rise until the cycle after the write response.
